seg7_scan: RTL and testbench

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It is the output-side counterpart to the push-button debounce path: debounce conditions user input, and this block presents CPU state (PC, register or bus values) back to the user. Each digit is shown in a fixed time slot, with a blanking gap at the start of each slot to suppress ghosting. Input data is captured into a shadow register once per frame, so a digit never changes mid-frame.

---
 rtl/seg7_scan.sv | 92 +++++++++
 tb/tb_seg7_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Inputs are shadowed once per frame so a digit never changes mid-frame.
module seg7_scan #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic [1:0]       idx_p0, idx_nxt;
  logic [15:0]      sh_data_p0, sh_data_nxt;
  logic [3:0]       sh_dp_p0, sh_dp_nxt;
  logic [3:0]       sh_blank_p0, sh_blank_nxt;
  logic             wrap, cap, en;
  logic [3:0]       nib;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  always_comb begin
    wrap         = (cnt_p0 == CNT_LAST);
    cap          = wrap && (idx_p0 == 2'd3);
    cnt_nxt      = wrap ? '0 : cnt_p0 + 1'b1;
    idx_nxt      = wrap ? idx_p0 + 2'd1 : idx_p0;
    sh_data_nxt  = cap ? data  : sh_data_p0;
    sh_dp_nxt    = cap ? dp_in : sh_dp_p0;
    sh_blank_nxt = cap ? blank : sh_blank_p0;
    // Outputs are registered from the next state so they line up with the
    // state register: the capture cycle is the first blanking cycle of digit 0.
    nib     = sh_data_nxt[{idx_nxt, 2'b00} +: 4];
    en      = (cnt_nxt >= CNT_BLANK) && !sh_blank_nxt[idx_nxt];
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (en) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = hex_decode(nib);
      dp_nxt  = ~sh_dp_nxt[idx_nxt];
    end
  end

  // Stage p0: scan state and shadow; stage p1: display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0      <= '0;
      idx_p0      <= 2'd0;
      sh_data_p0  <= 16'h0000;
      sh_dp_p0    <= 4'h0;
      sh_blank_p0 <= 4'hF;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      cnt_p0      <= cnt_nxt;
      idx_p0      <= idx_nxt;
      sh_data_p0  <= sh_data_nxt;
      sh_dp_p0    <= sh_dp_nxt;
      sh_blank_p0 <= sh_blank_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_done  <= cap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with a frame-position reference model.
module tb_seg7_scan;
  localparam int S = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: k counts clock edges since reset release; every FRAME
  // edges the inputs are captured and the frame position picks the digit.
  int          k = 0;
  logic [15:0] m_data = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_blank = 4'hF;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fd = 1'b0;

  always @(posedge clk) begin
    int p, d, off;
    logic [3:0] nibv;
    if (!rst_n) begin
      k = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'hF; e_fd = 1'b0;
    end else begin
      k = k + 1;
      e_fd = (k % FRAME == 0);
      if (e_fd) begin
        m_data = data; m_dp = dp_in; m_blank = blank;
      end
    end
    p = k % FRAME;
    d = p / S;
    off = p % S;
    nibv = 4'((m_data >> (4 * d)) & 16'hF);
    if (off >= B && !m_blank[d]) begin
      e_an = 4'hF; e_an[d] = 1'b0;
      e_seg = dec[nibv];
      e_dp = ~m_dp[d];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state got an=%h seg=%h dp=%b fd=%b want an=f seg=7f dp=1 fd=0", an, seg, dp, frame_done);
      end
    end
    data = 16'h1234; blank = 4'h0; dp_in = 4'h0; rst_n = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL first_frame k=%0d got %h/%h/%b/%b want %h/%h/%b/%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (frame_done !== 1'b1) begin
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
          errors++;
          $display("FAIL dark_before_capture got an=%h seg=%h want an=f seg=7f", an, seg);
        end
      end
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL first_capture_latency got %0d want %0d", n, FRAME);
    end
  endtask

  task automatic test_scan();
    int lit [4];
    int fds;
    fds = 0;
    for (int d = 0; d < 4; d++) lit[d] = 0;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL scan k=%0d got %h/%h/%b/%b want %h/%h/%b/%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      for (int d = 0; d < 4; d++) if (an == ~(4'b0001 << d)) lit[d]++;
      if (frame_done === 1'b1) fds++;
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lit[d] != 2 * (S - B)) begin
        errors++;
        $display("FAIL slot_width digit%0d got %0d want %0d", d, lit[d], 2 * (S - B));
      end
    end
    checks++;
    if (fds != 2) begin
      errors++;
      $display("FAIL frame_period got %0d pulses want 2", fds);
    end
  endtask

  task automatic test_no_tearing();
    int n;
    logic [6:0] want;
    n = 0;
    while (!((k % FRAME) >= S + B && (k % FRAME) < 2 * S) && n < 2 * FRAME) begin
      tick(); n++;
    end
    data = 16'hABCD;
    n = 0;
    do begin
      tick(); n++;
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL tear_cur k=%0d got %h/%h/%b/%b want %h/%h/%b/%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (an == 4'b0111 && frame_done !== 1'b1) begin
        checks++;
        if (seg !== 7'h79) begin
          errors++;
          $display("FAIL tear_old_digit3 got seg=%h want 79", seg);
        end
      end
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL tear_wait_timeout got fd=%b want 1", frame_done);
    end
    repeat (FRAME) begin
      tick();
      case (an)
        4'hE: want = 7'h21;
        4'hD: want = 7'h46;
        4'hB: want = 7'h03;
        4'h7: want = 7'h08;
        default: want = 7'h7F;
      endcase
      checks++;
      if (seg !== want) begin
        errors++;
        $display("FAIL tear_new_frame an=%h got seg=%h want %h", an, seg, want);
      end
    end
  endtask

  task automatic test_blank_dp();
    int n;
    blank = 4'b0100; dp_in = 4'b0001;
    n = 0;
    do begin
      tick(); n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL blank_wait_timeout got fd=%b want 1", frame_done);
    end
    repeat (FRAME) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL blank_model k=%0d got %h/%h/%b/%b want %h/%h/%b/%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (an[2] !== 1'b1 || dp !== ((an == 4'hE) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL blank_dp got an=%h dp=%b want an[2]=1 dp=%b", an, dp, (an == 4'hE) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    blank = 4'h0; dp_in = 4'h0;
    n = 0;
    do begin
      tick(); n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    n = 0;
    while (!((k % FRAME) >= 2 * S + B && (k % FRAME) < 3 * S) && n < 2 * FRAME) begin
      tick(); n++;
    end
    checks++;
    if (an !== 4'hB) begin
      errors++;
      $display("FAIL mid_digit2_lit got an=%h want b", an);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b fd=%b want f/7f/1/0", an, seg, dp, frame_done);
    end
    repeat (FRAME - 1) begin
      tick();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_dark got an=%h seg=%h fd=%b want f/7f/0", an, seg, frame_done);
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || an !== 4'hF) begin
      errors++;
      $display("FAIL mid_recapture got fd=%b an=%h want fd=1 an=f", frame_done, an);
    end
  endtask

  task automatic test_decode();
    logic [15:0] pats [8];
    int n;
    pats[0] = 16'h3210; pats[1] = 16'h7654; pats[2] = 16'hBA98; pats[3] = 16'hFEDC;
    for (int i = 4; i < 8; i++) pats[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      data = pats[i];
      blank = (i < 4) ? 4'h0 : 4'($urandom);
      dp_in = 4'($urandom);
      n = 0;
      do begin
        tick(); n++;
      end while (frame_done !== 1'b1 && n < 2 * FRAME);
      repeat (FRAME) begin
        if (i >= 4 && $urandom_range(7) == 0) begin
          data = 16'($urandom); blank = 4'($urandom); dp_in = 4'($urandom);
        end
        tick();
        checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
          errors++;
          $display("FAIL decode k=%0d got %h/%h/%b/%b want %h/%h/%b/%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        end
        checks++;
        if ($countones(~an) > 1) begin
          errors++;
          $display("FAIL exclusivity got an=%h want at most one low bit", an);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tearing();
    test_blank_dp();
    test_reset_mid();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
